// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and count types for the VGA timing producer
// and the block/pixel controllers that consume hCount/vCount/bright.
package vga_timing_pkg;

  localparam int COUNT_W = 10;
  localparam int DIV_W   = 4;

  typedef logic [COUNT_W-1:0] count_t;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

  // Top-left corner of the visible area in raster counts.
  localparam int H_VIS_START = DEF_H_SYNC + DEF_H_BP;
  localparam int V_VIS_START = DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/pixel_en_div.sv
// Divides the system clock into a registered one-clk pixel enable, high while the
// divider sits at its last value.
module pixel_en_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  always_comb begin
    div_next = div + 1'b1;
    if (div == DIV_LAST) div_next = '0;
  end

  // pix_en is decoded from the next divider value so it lines up with div==CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_next;
      pix_en <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing producer: hCount/vCount, active-low syncs, bright, pixel enable
// and line/frame ticks, all running on clk with a divided pixel enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               pix_en,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_param_err
    $error("vga_timing_gen: raster totals must be <= 1024 and CLK_DIV in 1..16");
  end

  localparam count_t H_LAST     = count_t'(H_TOT - 1);
  localparam count_t V_LAST     = count_t'(V_TOT - 1);
  localparam count_t H_SYNC_END = count_t'(H_SYNC);
  localparam count_t V_SYNC_END = count_t'(V_SYNC);
  localparam count_t H_VIS_LO   = count_t'(H_SYNC + H_BP);
  localparam count_t H_VIS_HI   = count_t'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam count_t V_VIS_LO   = count_t'(V_SYNC + V_BP);
  localparam count_t V_VIS_HI   = count_t'(V_SYNC + V_BP + V_ACTIVE - 1);

  count_t h_next;
  count_t v_next;

  pixel_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_next = hCount;
    v_next = vCount;
    if (pix_en) begin
      if (hCount == H_LAST) begin
        h_next = '0;
        v_next = (vCount == V_LAST) ? '0 : vCount + 1'b1;
      end else begin
        h_next = hCount + 1'b1;
      end
    end
  end

  // Syncs and bright decode the next-state counts so they never lag hCount/vCount.
  always_ff @(posedge clk) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
      hSync  <= 1'b0;
      vSync  <= 1'b0;
      bright <= 1'b0;
    end else begin
      hCount <= h_next;
      vCount <= v_next;
      hSync  <= (h_next >= H_SYNC_END);
      vSync  <= (v_next >= V_SYNC_END);
      bright <= (h_next >= H_VIS_LO) && (h_next <= H_VIS_HI) &&
                (v_next >= V_VIS_LO) && (v_next <= V_VIS_HI);
    end
  end

  assign line_tick  = pix_en && (hCount == H_LAST);
  assign frame_tick = line_tick && (vCount == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default raster at /4, small raster at /1
// and /4) checked every clk against a pixel-index reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    longint d;
    longint hs, hbp, ha, hfp;
    longint vs, vbp, va, vfp;
  } geom_t;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       pe;
    logic       lt;
    logic       ft;
  } obs_t;

  localparam geom_t GA = '{d:4, hs:96, hbp:48, ha:640, hfp:16, vs:2, vbp:33, va:480, vfp:10};
  localparam geom_t GB = '{d:1, hs:8, hbp:5, ha:20, hfp:3, vs:2, vbp:3, va:10, vfp:2};
  localparam geom_t GC = '{d:4, hs:8, hbp:5, ha:20, hfp:3, vs:2, vbp:3, va:10, vfp:2};

  localparam int NCYC = 12000;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
  logic hs_a, vs_a, br_a, pe_a, lt_a, ft_a;
  logic hs_b, vs_b, br_b, pe_b, lt_b, ft_b;
  logic hs_c, vs_c, br_c, pe_c, lt_c, ft_c;
  obs_t obs_a, obs_b, obs_c;

  int compared = 0;
  int mismatched = 0;

  vga_timing_gen #(.CLK_DIV(4)) u_a (
    .clk(clk), .rst(rst_a), .hCount(hc_a), .vCount(vc_a), .hSync(hs_a), .vSync(vs_a),
    .bright(br_a), .pix_en(pe_a), .line_tick(lt_a), .frame_tick(ft_a));

  vga_timing_gen #(.CLK_DIV(1), .H_SYNC(8), .H_BP(5), .H_ACTIVE(20), .H_FP(3),
                   .V_SYNC(2), .V_BP(3), .V_ACTIVE(10), .V_FP(2)) u_b (
    .clk(clk), .rst(rst_b), .hCount(hc_b), .vCount(vc_b), .hSync(hs_b), .vSync(vs_b),
    .bright(br_b), .pix_en(pe_b), .line_tick(lt_b), .frame_tick(ft_b));

  vga_timing_gen #(.CLK_DIV(4), .H_SYNC(8), .H_BP(5), .H_ACTIVE(20), .H_FP(3),
                   .V_SYNC(2), .V_BP(3), .V_ACTIVE(10), .V_FP(2)) u_c (
    .clk(clk), .rst(rst_c), .hCount(hc_c), .vCount(vc_c), .hSync(hs_c), .vSync(vs_c),
    .bright(br_c), .pix_en(pe_c), .line_tick(lt_c), .frame_tick(ft_c));

  assign obs_a = {hc_a, vc_a, hs_a, vs_a, br_a, pe_a, lt_a, ft_a};
  assign obs_b = {hc_b, vc_b, hs_b, vs_b, br_b, pe_b, lt_b, ft_b};
  assign obs_c = {hc_c, vc_c, hs_c, vs_c, br_c, pe_c, lt_c, ft_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k = clk edges taken with rst low since the last reset edge. The raster is a single
  // pixel index n that advances once per CLK_DIV clks, split into (h, v) by division.
  function automatic obs_t model(input geom_t g, input longint k);
    obs_t   e;
    longint ht, vt, n, h, v;
    logic   pe;
    ht = g.hs + g.hbp + g.ha + g.hfp;
    vt = g.vs + g.vbp + g.va + g.vfp;
    pe = (k >= 1) && ((g.d == 1) || ((k % g.d) == (g.d - 1)));
    if (g.d == 1) n = (k >= 1) ? k - 1 : 0;
    else          n = k / g.d;
    h = n % ht;
    v = (n / ht) % vt;
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.hs = (h >= g.hs);
    e.vs = (v >= g.vs);
    e.br = (h >= g.hs + g.hbp) && (h < g.hs + g.hbp + g.ha) &&
           (v >= g.vs + g.vbp) && (v < g.vs + g.vbp + g.va);
    e.pe = pe;
    e.lt = pe && (h == ht - 1);
    e.ft = pe && (h == ht - 1) && (v == vt - 1);
    return e;
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e, input longint k);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s k=%0d observed h=%0d v=%0d hs=%b vs=%b br=%b pe=%b lt=%b ft=%b expected h=%0d v=%0d hs=%b vs=%b br=%b pe=%b lt=%b ft=%b",
             tag, k, o.h, o.v, o.hs, o.vs, o.br, o.pe, o.lt, o.ft,
             e.h, e.v, e.hs, e.vs, e.br, e.pe, e.lt, e.ft);
    end
  endtask

  task automatic check_val(input string tag, input longint o, input longint e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  longint ka, kb, kc;
  longint last_lt_a, last_ft_b, last_ft_c;
  int     lt_cnt_a, ft_cnt_b, ft_cnt_c, hold_b;
  bit     a_done, c_done, a_chk, c_chk;
  obs_t   ea, eb, ec;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ka = 0; kb = 0; kc = 0;
    last_lt_a = -1; last_ft_b = -1; last_ft_c = -1;
    lt_cnt_a = 0; ft_cnt_b = 0; ft_cnt_c = 0; hold_b = 0;
    a_done = 0; c_done = 0; a_chk = 0; c_chk = 0;

    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_a", obs_a, obs_t'(0), 0);
      check("reset_b", obs_b, obs_t'(0), 0);
      check("reset_c", obs_c, obs_t'(0), 0);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      ka = rst_a ? 0 : ka + 1;
      kb = rst_b ? 0 : kb + 1;
      kc = rst_c ? 0 : kc + 1;
      if (rst_a) last_lt_a = -1;
      if (rst_b) last_ft_b = -1;
      if (rst_c) last_ft_c = -1;
      #1;
      ea = model(GA, ka);
      eb = model(GB, kb);
      ec = model(GC, kc);
      check("raster_a", obs_a, ea, ka);
      check("raster_b", obs_b, eb, kb);
      check("raster_c", obs_c, ec, kc);

      if (a_chk) begin
        check("midframe_reset_a", obs_a, obs_t'(0), ka);
        a_chk = 0;
      end
      if (c_chk) begin
        check("midframe_reset_c", obs_c, obs_t'(0), kc);
        c_chk = 0;
      end
      if (ka == 3 && !a_done) check_val("first_pix_en_a", longint'(pe_a), 1);
      if (ka == 4 && !a_done) check_val("first_advance_a", longint'(hc_a), 1);

      if (lt_a) begin
        lt_cnt_a++;
        if (last_lt_a >= 0) check_val("line_period_a", ka - last_lt_a, 3200);
        last_lt_a = ka;
      end
      if (ft_b) begin
        ft_cnt_b++;
        if (last_ft_b >= 0) check_val("frame_period_b", kb - last_ft_b, 612);
        last_ft_b = kb;
      end
      if (ft_c) begin
        ft_cnt_c++;
        if (last_ft_c >= 0) check_val("frame_period_c", kc - last_ft_c, 2448);
        last_ft_c = kc;
      end

      // A: one-clk reset once the raster reaches (400,2); C: at (18,9) in its second frame.
      if (rst_a) rst_a = 1'b0;
      else if (!a_done && ea.h == 10'd400 && ea.v == 10'd2) begin
        rst_a = 1'b1; a_done = 1; a_chk = 1;
      end
      if (rst_c) rst_c = 1'b0;
      else if (!c_done && kc > 2448 && ec.h == 10'd18 && ec.v == 10'd9) begin
        rst_c = 1'b1; c_done = 1; c_chk = 1;
      end
      // B: random reset pulses of 1..3 clks.
      if (hold_b > 0) begin
        hold_b--;
        rst_b = (hold_b > 0);
      end else if ($urandom_range(0, 999) == 0) begin
        hold_b = int'($urandom_range(1, 3));
        rst_b  = 1'b1;
      end
    end

    check_val("reset_a_taken", longint'(a_done), 1);
    check_val("reset_c_taken", longint'(c_done), 1);
    check_val("line_ticks_a_seen", longint'(lt_cnt_a > 2), 1);
    check_val("frame_ticks_c_seen", longint'(ft_cnt_c > 2), 1);
    check_val("frame_ticks_b_seen", longint'(ft_cnt_b > 2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing: hCount/vCount, active-low hSync/vSync, bright, and a pixel-rate enable.
It is the producer end of the hCount/vCount/bright interface consumed by the block and pixel controllers, which map those counts to rgb.
Runs from the 100 MHz board clock with an internal pixel-enable divider, so no derived clock is used.
Also provides line and frame ticks that game logic can use as a slow update strobe.

Parameters:
CLK_DIV, 4, system clocks per pixel (1..16); 4 gives 25 MHz pixel rate from 100 MHz
H_SYNC, 96, hSync pulse width in pixels
H_BP, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
V_SYNC, 2, vSync pulse width in lines
V_BP, 33, vertical back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
hCount  out  10  horizontal pixel counter, 0..H_TOTAL-1
vCount  out  10  vertical line counter, 0..V_TOTAL-1
hSync  out  1  horizontal sync, active low
vSync  out  1  vertical sync, active low
bright  out  1  high when the current (hCount,vCount) is in the visible area
pix_en  out  1  one-clk pulse, once per pixel period
line_tick  out  1  one-clk pulse on the last pixel of each line
frame_tick  out  1  one-clk pulse on the last pixel of each frame

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Every register resets only on a clk edge with rst=1.
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800). V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (525).
- Elaboration-time error if H_TOTAL>1024, V_TOTAL>1024, or CLK_DIV is outside 1..16.
- Reset values: hCount=0, vCount=0, hSync=0, vSync=0, bright=0, pix_en=0, line_tick=0, frame_tick=0, divider=0.
- Divider: counts 0..CLK_DIV-1 and wraps.
- pix_en is registered and high during the clk in which the divider equals CLK_DIV-1.
- First pix_en occurs in the CLK_DIV-th clk after rst deasserts. With CLK_DIV=1, pix_en is constant 1 after the first post-reset clk.
- Counters advance only on a clk edge where pix_en=1. Each (hCount,vCount) value is therefore held for exactly CLK_DIV clks.
- Horizontal wrap: if hCount==H_TOTAL-1, then hCount goes to 0 and vCount increments. Otherwise hCount increments.
- Vertical wrap: if vCount==V_TOTAL-1 and hCount wraps, vCount goes to 0.
- Sync pulses start at count 0:
  - hSync=0 iff hCount<H_SYNC.
  - vSync=0 iff vCount<V_SYNC.
- Visible area is hCount in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = 144..783, and vCount in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] = 35..514. bright=1 iff both hold.
- hSync, vSync and bright are registered and decoded from the next-state counts, so they always match the hCount/vCount presented in the same clk. There is no skew.
- line_tick = pix_en AND hCount==H_TOTAL-1.
- frame_tick = pix_en AND hCount==H_TOTAL-1 AND vCount==V_TOTAL-1.
- Both ticks are single-clk pulses coincident with pix_en.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000 at defaults).
- rst asserted mid-frame: on the next edge all outputs and the divider return to their reset values, and the sequence restarts exactly as after power-up.
- Outputs never take values outside their count ranges.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480 porch/sync constants and derived H_TOTAL/V_TOTAL;
  - visible-area origin constants (144, 35);
  - a 10-bit count width constant shared with downstream controllers.
- Sub-module pixel_en_div: parameter CLK_DIV; ports clk, rst, pix_en. It holds the divider counter and pix_en register. The raster counters, decode logic and ticks stay in vga_timing_gen.

Test Plan:
1. Reset and startup: hold rst 3 clks, then release with CLK_DIV=4 -> during reset all outputs are 0; first pix_en in clk 4 after release; hCount becomes 1 at the following edge; vCount stays 0.
2. Horizontal timing: run one line -> hSync=0 for hCount 0..95 and 1 for 96..799; hCount 799->0 with vCount 0->1; line_tick pulses once; line period is 3200 clks.
3. bright boundaries -> bright=0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), 0 at (144,34), 0 at (144,515); hSync, vSync and bright stay aligned to the same-clk counts.
4. Full frame -> vSync=0 only for vCount 0..1; frame_tick pulses exactly once at (799,524), and the next counts are (0,0); frame_tick-to-frame_tick spacing is 1,680,000 clks; no other pulses occur.
5. Mid-frame reset: assert rst for 1 clk at (400,300) -> the next clk shows all outputs 0; the output trace after release is identical to scenario 1.
6. CLK_DIV=1 build -> pix_en is constantly 1 after reset; hCount increments every clk; frame period is 420,000 clks; bright/sync boundaries are the same as scenarios 3 and 4.
